// File: rtl/burst_write_block.sv
// burst_write_block: FIFO-buffered burst write master streaming BURST_WORDS-word bursts over a wrapping address window.
// Optional BURST_WRITE_FLUSH_EN adds a flush input that issues a partial burst of whatever is buffered.
module burst_write_block #(
    parameter int BURST_WORDS = 32,
    parameter int FIFO_AW     = 8,
    parameter int FRAME_BYTES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        restart,
`ifdef BURST_WRITE_FLUSH_EN
    input  logic        flush,
`endif
    input  logic [31:0] start_address,
    input  logic        write,
    input  logic [31:0] write_data,
    output logic [12:0] count_in_buf,
    output logic        full,
    output logic        overflow,
    output logic        bus_error,
    output logic        ip2bus_mstwr_req,
    output logic        ip2bus_mst_type,
    output logic [31:0] ip2bus_mst_addr,
    output logic [11:0] ip2bus_mst_length,
    output logic [31:0] ip2bus_mstwr_d,
    output logic        ip2bus_mstwr_sof_n,
    output logic        ip2bus_mstwr_eof_n,
    output logic        ip2bus_mstwr_src_rdy_n,
    input  logic        bus2ip_mst_cmdack,
    input  logic        bus2ip_mst_cmplt,
    input  logic        bus2ip_mst_error,
    input  logic        bus2ip_mstwr_dst_rdy_n
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [12:0] BW = 13'(BURST_WORDS);
    localparam logic [11:0] FULL_LEN = 12'(BURST_WORDS * 4);

    typedef enum logic [1:0] {IDLE, REQ, DATA, CMPLT} state_t;

    logic [31:0] mem [DEPTH];
    state_t state_q, state_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [12:0] count_q, count_d, beats_q, beats_d, total_q, total_d;
    logic [31:0] offset_q, offset_d;
    logic [11:0] length_q, length_d;
    logic overflow_q, overflow_d, bus_error_q, bus_error_d, pending_q, pending_d;
    logic req_q, req_d, sof_n_q, sof_n_d, eof_n_q, eof_n_d, src_rdy_n_q, src_rdy_n_d;
    logic push, beat, clear, part;
    logic [12:0] issue;
    logic [31:0] wrap_sum;

    assign full = count_q == 13'(DEPTH);
    assign push = write && !full;
    assign beat = !src_rdy_n_q && !bus2ip_mstwr_dst_rdy_n;
    assign clear = state_q == IDLE && (pending_q || restart);
`ifdef BURST_WRITE_FLUSH_EN
    assign part = flush && count_q != 13'd0 && count_q < BW;
`else
    assign part = 1'b0;
`endif
    assign issue = count_q >= BW ? BW : count_q;
    assign wrap_sum = offset_q + {20'd0, length_q};

    always_comb begin
        state_d = state_q;
        wr_ptr_d = clear ? '0 : wr_ptr_q + FIFO_AW'(push);
        rd_ptr_d = clear ? '0 : rd_ptr_q + FIFO_AW'(beat);
        count_d = clear ? '0 : count_q + 13'(push) - 13'(beat);
        offset_d = clear ? '0 : offset_q;
        pending_d = clear ? 1'b0 : pending_q | restart;
        beats_d = beats_q - 13'(beat);
        total_d = total_q;
        length_d = length_q;
        overflow_d = overflow_q | (write & full);
        bus_error_d = bus_error_q;
        case (state_q)
            IDLE: if (!clear && (count_q >= BW || part)) begin
                state_d = REQ;
                beats_d = issue;
                total_d = issue;
                length_d = 12'(issue << 2);
            end
            REQ: if (bus2ip_mst_cmdack) state_d = DATA;
            DATA: if (beat && beats_q == 13'd1) state_d = CMPLT;
            CMPLT: if (bus2ip_mst_cmplt) begin
                bus_error_d = bus_error_q | bus2ip_mst_error;
                offset_d = wrap_sum >= 32'(FRAME_BYTES) ? '0 : wrap_sum;
                state_d = IDLE;
            end
        endcase
        // Framing is registered from next-state values so it holds through dst_rdy_n stalls
        req_d = state_d == REQ;
        src_rdy_n_d = state_d != DATA;
        sof_n_d = !(state_d == DATA && beats_d == total_d);
        eof_n_d = !(state_d == DATA && beats_d == 13'd1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
            offset_q <= '0;
            pending_q <= 1'b0;
            beats_q <= '0;
            total_q <= '0;
            length_q <= FULL_LEN;
            overflow_q <= 1'b0;
            bus_error_q <= 1'b0;
            req_q <= 1'b0;
            sof_n_q <= 1'b1;
            eof_n_q <= 1'b1;
            src_rdy_n_q <= 1'b1;
        end else begin
            state_q <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
            offset_q <= offset_d;
            pending_q <= pending_d;
            beats_q <= beats_d;
            total_q <= total_d;
            length_q <= length_d;
            overflow_q <= overflow_d;
            bus_error_q <= bus_error_d;
            req_q <= req_d;
            sof_n_q <= sof_n_d;
            eof_n_q <= eof_n_d;
            src_rdy_n_q <= src_rdy_n_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr_q] <= write_data;
    end

    assign count_in_buf = count_q;
    assign overflow = overflow_q;
    assign bus_error = bus_error_q;
    assign ip2bus_mstwr_req = req_q;
    assign ip2bus_mst_type = req_q;
    assign ip2bus_mst_addr = start_address + offset_q;
    assign ip2bus_mst_length = length_q;
    assign ip2bus_mstwr_d = mem[rd_ptr_q];
    assign ip2bus_mstwr_sof_n = sof_n_q;
    assign ip2bus_mstwr_eof_n = eof_n_q;
    assign ip2bus_mstwr_src_rdy_n = src_rdy_n_q;
endmodule
